// File: rtl/vrf_pkg.sv
// Shared state encoding, default sizing and the lane-merge rule for the vector register file.
package vrf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_t;

    localparam int NREGS_DEF    = 16;
    localparam int LANES_DEF    = 4;
    localparam int LANE_W_DEF   = 32;
    localparam int NRD_DEF      = 3;
    localparam int ZERO_REG_DEF = 1;
    localparam int BYPASS_DEF   = 1;

    // Per-bit merge keeps the rule independent of lane width: masked lanes take
    // their own write lane, or lane 0 when broadcasting; unmasked lanes keep old data.
    function automatic logic merge_bit(logic old_bit, logic own_bit, logic lane0_bit,
                                       logic mask_bit, logic bcast);
        return mask_bit ? (bcast ? lane0_bit : own_bit) : old_bit;
    endfunction

endpackage

// File: rtl/vrf_scoreboard.sv
// Per-register busy bits: reservations set, writes clear, the clear sequencer wipes one index per cycle.
module vrf_scoreboard
    import vrf_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en_i,
    input  logic [AW-1:0]    set_addr_i,
    input  logic             clr_en_i,
    input  logic [AW-1:0]    clr_addr_i,
    input  logic             seq_clr_en_i,
    input  logic [AW:0]      seq_clr_idx_i,
    output logic [NREGS-1:0] busy_o
);

    logic [NREGS-1:0] busy_q, busy_d;

    // A reservation is applied after the write clear so it wins on a same-address collision.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (clr_en_i && clr_addr_i == AW'(r))
                busy_d[r] = 1'b0;
            if (set_en_i && set_addr_i == AW'(r))
                busy_d[r] = 1'b1;
            if (seq_clr_en_i && seq_clr_idx_i == (AW+1)'(r))
                busy_d[r] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/vector_register_file.sv
// Vector register file: NRD combinational read ports, one lane-masked/broadcast write port
// with bypass, a busy scoreboard and a handshaked multi-cycle bulk-clear sequencer.
module vector_register_file
    import vrf_pkg::*;
#(
    parameter  int NREGS    = NREGS_DEF,
    parameter  int LANES    = LANES_DEF,
    parameter  int LANE_W   = LANE_W_DEF,
    parameter  int NRD      = NRD_DEF,
    parameter  int ZERO_REG = ZERO_REG_DEF,
    parameter  int BYPASS   = BYPASS_DEF,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NRD*AW-1:0]           rs_addr,
    output logic [NRD*LANES*LANE_W-1:0] rd_data,
    output logic [NRD-1:0]              rd_busy,
    input  logic                        wr_enable,
    input  logic [AW-1:0]               wr_addr,
    input  logic [LANES-1:0]            wr_lane_mask,
    input  logic                        wr_bcast,
    input  logic [LANES*LANE_W-1:0]     wr_data,
    input  logic                        rsv_valid,
    input  logic [AW-1:0]               rsv_addr,
    input  logic                        clr_req,
    output logic                        clr_ready,
    output logic                        clr_done
);

    logic [LANE_W-1:0] regs_q [NREGS][LANES];
    logic [LANE_W-1:0] wr_row [LANES];
    logic [NREGS-1:0]  busy;
    clr_state_t        state_q, state_d;
    logic [AW:0]       idx_q, idx_d;
    logic              fsm_idle, seq_clr, wr_take, wr_apply, rsv_take;

    function automatic logic addr_usable(logic [AW-1:0] a);
        return (32'(a) < NREGS) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign fsm_idle = (state_q == IDLE);
    assign seq_clr  = (state_q == CLEAR);
    assign wr_take  = fsm_idle && wr_enable && addr_usable(wr_addr);
    assign wr_apply = wr_take && (|wr_lane_mask);
    assign rsv_take = fsm_idle && rsv_valid && addr_usable(rsv_addr);

    // Full post-write image of the destination row; feeds both storage and bypass.
    always_comb begin
        for (int j = 0; j < LANES; j++)
            for (int b = 0; b < LANE_W; b++)
                wr_row[j][b] = merge_bit(regs_q[wr_addr][j][b], wr_data[j*LANE_W+b],
                                         wr_data[b], wr_lane_mask[j], wr_bcast);
    end

    // NOTE: the array is reset because reset must leave every lane reading zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                for (int j = 0; j < LANES; j++)
                    regs_q[r][j] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (seq_clr && idx_q == (AW+1)'(r)) begin
                    for (int j = 0; j < LANES; j++)
                        regs_q[r][j] <= '0;
                end else if (wr_apply && wr_addr == AW'(r)) begin
                    for (int j = 0; j < LANES; j++)
                        regs_q[r][j] <= wr_row[j];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (addr_usable(rs_addr[i*AW +: AW])) begin
                rd_busy[i] = busy[rs_addr[i*AW +: AW]];
                for (int j = 0; j < LANES; j++)
                    rd_data[(i*LANES+j)*LANE_W +: LANE_W] =
                        (BYPASS != 0 && wr_apply && rs_addr[i*AW +: AW] == wr_addr)
                            ? wr_row[j] : regs_q[rs_addr[i*AW +: AW]][j];
            end
        end
    end

    vrf_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .set_en_i      (rsv_take),
        .set_addr_i    (rsv_addr),
        .clr_en_i      (wr_take),
        .clr_addr_i    (wr_addr),
        .seq_clr_en_i  (seq_clr),
        .seq_clr_idx_i (idx_q),
        .busy_o        (busy)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        clr_ready = 1'b0;
        clr_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                clr_ready = 1'b1;
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + (AW+1)'(1);
                if (idx_q == (AW+1)'(NREGS - 1))
                    state_d = DONE;
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vector_register_file.sv
// Self-checking bench for vector_register_file: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register contents and busy bits.
module tb_vector_register_file;

    localparam int NREGS  = 16;
    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int NRD    = 3;
    localparam int AW     = 4;
    localparam int ROW_W  = LANES * LANE_W;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NRD*AW-1:0]           rs_addr;
    logic [NRD*LANES*LANE_W-1:0] rd_data;
    logic [NRD-1:0]              rd_busy;
    logic                        wr_enable;
    logic [AW-1:0]               wr_addr;
    logic [LANES-1:0]            wr_lane_mask;
    logic                        wr_bcast;
    logic [LANES*LANE_W-1:0]     wr_data;
    logic                        rsv_valid;
    logic [AW-1:0]               rsv_addr;
    logic                        clr_req;
    logic                        clr_ready;
    logic                        clr_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [LANE_W-1:0] m_regs [NREGS][LANES];
    logic              m_busy [NREGS];

    vector_register_file dut (
        .clk          (clk),
        .rst          (rst),
        .rs_addr      (rs_addr),
        .rd_data      (rd_data),
        .rd_busy      (rd_busy),
        .wr_enable    (wr_enable),
        .wr_addr      (wr_addr),
        .wr_lane_mask (wr_lane_mask),
        .wr_bcast     (wr_bcast),
        .wr_data      (wr_data),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .clr_req      (clr_req),
        .clr_ready    (clr_ready),
        .clr_done     (clr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    task automatic model_zero();
        for (int r = 0; r < NREGS; r++) begin
            m_busy[r] = 1'b0;
            for (int j = 0; j < LANES; j++) m_regs[r][j] = '0;
        end
    endtask

    // Expected read of one lane while the sequencer is idle, including same-cycle forwarding.
    function automatic logic [LANE_W-1:0] exp_lane(int a, int j);
        if (a == 0) return '0;
        if (wr_enable && int'(wr_addr) == a && wr_lane_mask[j])
            return wr_bcast ? wr_data[LANE_W-1:0] : wr_data[j*LANE_W +: LANE_W];
        return m_regs[a][j];
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(int a);
        logic [ROW_W-1:0] e;
        for (int j = 0; j < LANES; j++) e[j*LANE_W +: LANE_W] = exp_lane(a, j);
        return e;
    endfunction

    function automatic logic exp_busy(int a);
        return (a == 0) ? 1'b0 : m_busy[a];
    endfunction

    function automatic logic [ROW_W-1:0] port_row(int p);
        return rd_data[p*ROW_W +: ROW_W];
    endfunction

    function automatic logic [ROW_W-1:0] row4(logic [31:0] l3, logic [31:0] l2,
                                             logic [31:0] l1, logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // Commit the current inputs to the model (idle sequencer), then advance one clock.
    task automatic cycle();
        if (wr_enable && wr_addr != '0) begin
            for (int j = 0; j < LANES; j++)
                if (wr_lane_mask[j])
                    m_regs[wr_addr][j] = wr_bcast ? wr_data[LANE_W-1:0] : wr_data[j*LANE_W +: LANE_W];
            m_busy[wr_addr] = 1'b0;
        end
        if (rsv_valid && rsv_addr != '0) m_busy[rsv_addr] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_enable    = 1'b0;
        wr_addr      = '0;
        wr_lane_mask = '0;
        wr_bcast     = 1'b0;
        wr_data      = '0;
        rsv_valid    = 1'b0;
        rsv_addr     = '0;
        clr_req      = 1'b0;
    endtask

    task automatic set_rs(int p, int a);
        rs_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic drive_write(int a, logic [LANES-1:0] mask, logic bcast, logic [ROW_W-1:0] data);
        wr_enable    = 1'b1;
        wr_addr      = AW'(a);
        wr_lane_mask = mask;
        wr_bcast     = bcast;
        wr_data      = data;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        rs_addr = '0;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (clr_ready !== 1'b1 || clr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: ready=%b done=%b, want ready=1 done=0", clr_ready, clr_done);
        end
        rst = 1'b0;
        #1;
        for (int a = 0; a < NREGS; a++) begin
            rs_addr = {NRD{AW'(a)}};
            #1;
            n_tests++;
            if (rd_data !== '0 || rd_busy !== '0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: data=%h busy=%b, want all zero", a, rd_data, rd_busy);
            end
        end
    endtask

    task automatic test_write_mask();
        idle_inputs();
        drive_write(3, 4'b1111, 1'b0, row4(32'd40, 32'd30, 32'd20, 32'd10));
        cycle();
        idle_inputs();
        set_rs(0, 3);
        #1;
        n_tests++;
        if (port_row(0) !== row4(32'd40, 32'd30, 32'd20, 32'd10)) begin
            n_fail++;
            $display("FAIL write_full_r3: got %h want %h", port_row(0), row4(32'd40, 32'd30, 32'd20, 32'd10));
        end
        drive_write(3, 4'b0101, 1'b0, row4(32'd4, 32'd3, 32'd2, 32'd1));
        cycle();
        idle_inputs();
        #1;
        n_tests++;
        if (port_row(0) !== row4(32'd40, 32'd3, 32'd20, 32'd1)) begin
            n_fail++;
            $display("FAIL write_mask_r3: got %h want %h", port_row(0), row4(32'd40, 32'd3, 32'd20, 32'd1));
        end
    endtask

    task automatic test_bypass();
        logic [ROW_W-1:0] d;
        idle_inputs();
        set_rs(0, 5);
        set_rs(1, 3);
        set_rs(2, 5);
        d = row4($urandom, $urandom, $urandom, 32'h0000_DEAD);
        drive_write(5, 4'b1111, 1'b1, d);
        #1;
        n_tests++;
        if (port_row(0) !== {LANES{32'h0000_DEAD}} || port_row(2) !== {LANES{32'h0000_DEAD}}) begin
            n_fail++;
            $display("FAIL bypass_bcast: p0=%h p2=%h want %h", port_row(0), port_row(2), {LANES{32'h0000_DEAD}});
        end
        n_tests++;
        if (port_row(1) !== row4(32'd40, 32'd3, 32'd20, 32'd1)) begin
            n_fail++;
            $display("FAIL bypass_other_port: got %h want %h", port_row(1), row4(32'd40, 32'd3, 32'd20, 32'd1));
        end
        cycle();
        idle_inputs();
        #1;
        n_tests++;
        if (port_row(0) !== {LANES{32'h0000_DEAD}}) begin
            n_fail++;
            $display("FAIL bcast_stored: got %h want %h", port_row(0), {LANES{32'h0000_DEAD}});
        end
        // Partial-mask broadcast seen combinationally on r5: lanes 1 and 3 forwarded.
        d = row4($urandom, $urandom, $urandom, 32'h0000_BEEF);
        drive_write(5, 4'b1010, 1'b1, d);
        #1;
        n_tests++;
        if (port_row(2) !== row4(32'h0000_BEEF, 32'h0000_DEAD, 32'h0000_BEEF, 32'h0000_DEAD)) begin
            n_fail++;
            $display("FAIL bypass_partial_bcast: got %h want %h", port_row(2),
                     row4(32'h0000_BEEF, 32'h0000_DEAD, 32'h0000_BEEF, 32'h0000_DEAD));
        end
        cycle();
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        set_rs(0, 0);
        drive_write(0, 4'b1111, 1'b0, {ROW_W{1'b1}});
        rsv_valid = 1'b1;
        rsv_addr  = '0;
        #1;
        n_tests++;
        if (port_row(0) !== '0 || rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_same_cycle: data=%h busy=%b want 0/0", port_row(0), rd_busy[0]);
        end
        cycle();
        idle_inputs();
        #1;
        n_tests++;
        if (port_row(0) !== '0 || rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_after: data=%h busy=%b want 0/0", port_row(0), rd_busy[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        set_rs(1, 7);
        rsv_valid = 1'b1;
        rsv_addr  = AW'(7);
        #1;
        n_tests++;
        if (rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_not_bypassed: busy=%b want 0", rd_busy[1]);
        end
        cycle();
        idle_inputs();
        #1;
        n_tests++;
        if (rd_busy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_sets_busy: busy=%b want 1", rd_busy[1]);
        end
        drive_write(7, 4'b1111, 1'b0, row4($urandom, $urandom, $urandom, $urandom));
        cycle();
        idle_inputs();
        #1;
        n_tests++;
        if (rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL write_clears_busy: busy=%b want 0", rd_busy[1]);
        end
        drive_write(7, 4'b1111, 1'b0, row4($urandom, $urandom, $urandom, $urandom));
        rsv_valid = 1'b1;
        rsv_addr  = AW'(7);
        cycle();
        idle_inputs();
        #1;
        n_tests++;
        if (rd_busy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_wins_collision: busy=%b want 1", rd_busy[1]);
        end
        drive_write(7, 4'b0000, 1'b0, row4($urandom, $urandom, $urandom, $urandom));
        cycle();
        idle_inputs();
        #1;
        n_tests++;
        if (rd_busy[1] !== 1'b0 || port_row(1) !== exp_row(7)) begin
            n_fail++;
            $display("FAIL zero_mask_write: busy=%b data=%h want busy=0 data=%h", rd_busy[1], port_row(1), exp_row(7));
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            wr_enable    = 1'($urandom_range(0, 1));
            wr_addr      = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREGS-1));
            wr_lane_mask = LANES'($urandom);
            wr_bcast     = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < LANES; j++) wr_data[j*LANE_W +: LANE_W] = $urandom;
            rsv_valid    = ($urandom_range(0, 2) == 0);
            rsv_addr     = ($urandom_range(0, 1) == 0) ? wr_addr : AW'($urandom_range(0, NREGS-1));
            for (int p = 0; p < NRD; p++)
                set_rs(p, ($urandom_range(0, 2) == 0) ? int'(wr_addr) : int'($urandom_range(0, NREGS-1)));
            #1;
            for (int p = 0; p < NRD; p++) begin
                n_tests++;
                if (port_row(p) !== exp_row(int'(rs_addr[p*AW +: AW]))) begin
                    n_fail++;
                    $display("FAIL rand_data it%0d p%0d r%0d: got %h want %h", it, p, rs_addr[p*AW +: AW],
                             port_row(p), exp_row(int'(rs_addr[p*AW +: AW])));
                end
                n_tests++;
                if (rd_busy[p] !== exp_busy(int'(rs_addr[p*AW +: AW]))) begin
                    n_fail++;
                    $display("FAIL rand_busy it%0d p%0d r%0d: got %b want %b", it, p, rs_addr[p*AW +: AW],
                             rd_busy[p], exp_busy(int'(rs_addr[p*AW +: AW])));
                end
            end
            cycle();
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int done_at;
        idle_inputs();
        for (int r = 1; r < NREGS; r++) begin
            drive_write(r, 4'b1111, 1'b0, row4($urandom | 1, $urandom | 1, $urandom | 1, $urandom | 1));
            cycle();
        end
        idle_inputs();
        rsv_valid = 1'b1;
        rsv_addr  = AW'(5);
        cycle();
        idle_inputs();
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        n_tests++;
        if (clr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ready_drops: ready=%b want 0", clr_ready);
        end
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 2) begin
                set_rs(1, 15);
                #1;
                n_tests++;
                if (port_row(1) !== exp_row(15)) begin
                    n_fail++;
                    $display("FAIL clear_live_read: got %h want %h", port_row(1), exp_row(15));
                end
            end
            if (k == 10) begin
                drive_write(2, 4'b1111, 1'b0, {LANES{32'hA5A5_0001}});
                rsv_valid = 1'b1;
                rsv_addr  = AW'(4);
                set_rs(2, 2);
                #1;
                n_tests++;
                if (port_row(2) !== '0) begin
                    n_fail++;
                    $display("FAIL clear_no_bypass: got %h want 0", port_row(2));
                end
            end
            @(posedge clk);
            #1;
            idle_inputs();
            if (clr_done === 1'b1) begin
                done_at = k;
                break;
            end
        end
        n_tests++;
        if (done_at != NREGS) begin
            n_fail++;
            $display("FAIL clr_done_timing: pulse after %0d cycles, want %0d", done_at, NREGS);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (clr_done !== 1'b0 || clr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_done_single: done=%b ready=%b want 0/1", clr_done, clr_ready);
        end
        model_zero();
        for (int a = 0; a < NREGS; a++) begin
            rs_addr = {NRD{AW'(a)}};
            #1;
            n_tests++;
            if (rd_data !== '0 || rd_busy !== '0) begin
                n_fail++;
                $display("FAIL cleared_reg%0d: data=%h busy=%b want all zero", a, rd_data, rd_busy);
            end
        end
    endtask

    task automatic test_clear_reset();
        bit seen_done;
        idle_inputs();
        for (int r = 1; r < NREGS; r++) begin
            drive_write(r, 4'b1111, 1'b0, row4($urandom | 1, $urandom | 1, $urandom | 1, $urandom | 1));
            cycle();
        end
        idle_inputs();
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (clr_ready !== 1'b1 || clr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_clear_fsm: ready=%b done=%b want 1/0", clr_ready, clr_done);
        end
        model_zero();
        for (int a = 0; a < NREGS; a++) begin
            rs_addr = {NRD{AW'(a)}};
            #1;
            n_tests++;
            if (rd_data !== '0) begin
                n_fail++;
                $display("FAIL rst_mid_clear_reg%0d: data=%h want 0", a, rd_data);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (clr_done !== 1'b0) seen_done = 1'b1;
        end
        n_tests++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL rst_no_done_pulse: clr_done seen=1 want 0");
        end
        drive_write(2, 4'b1111, 1'b0, row4(32'h1234_0003, 32'h1234_0002, 32'h1234_0001, 32'h1234_0000));
        cycle();
        idle_inputs();
        set_rs(0, 2);
        #1;
        n_tests++;
        if (port_row(0) !== row4(32'h1234_0003, 32'h1234_0002, 32'h1234_0001, 32'h1234_0000)) begin
            n_fail++;
            $display("FAIL write_after_rst: got %h want %h", port_row(0),
                     row4(32'h1234_0003, 32'h1234_0002, 32'h1234_0001, 32'h1234_0000));
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_write_mask();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_random();
        test_clear();
        test_clear_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_register_file.md
Name: vector_register_file

Overview:
- Parametrised successor to the scalar 16x32 register file.
- Holds NREGS vector registers, each LANES lanes of LANE_W bits.
- Provides NRD combinational read ports, one lane-masked/broadcast write port, write-to-read bypass and a per-register busy scoreboard.
- Includes a handshaked multi-cycle bulk-clear sequencer.
- Sits between decode (reads, reservations) and writeback in the vector pipeline.

Parameters:
- NREGS, 16: number of registers; AW = $clog2(NREGS).
- LANES, 4: lanes per register.
- LANE_W, 32: bits per lane.
- NRD, 3: number of read ports.
- ZERO_REG, 1: register 0 is hardwired to zero; writes and reservations to it are ignored.
- BYPASS, 1: a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs_addr  in  NRD*AW  read addresses; port i occupies [i*AW +: AW].
- rd_data  out  NRD*LANES*LANE_W  read data; port i, lane j occupies [(i*LANES+j)*LANE_W +: LANE_W].
- rd_busy  out  NRD  scoreboard bit of each addressed register.
- wr_enable  in  1  write strobe.
- wr_addr  in  AW  destination register.
- wr_lane_mask  in  LANES  lanes to write.
- wr_bcast  in  1  replicate lane 0 of wr_data into all masked lanes.
- wr_data  in  LANES*LANE_W  write data.
- rsv_valid  in  1  reserve (mark busy) a register.
- rsv_addr  in  AW  register to reserve.
- clr_req  in  1  request bulk clear.
- clr_ready  out  1  sequencer idle; clr_req accepted.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (asynchronous): all lanes of all registers = 0, all busy bits = 0, FSM = IDLE, clr_ready = 1, clr_done = 0. The reset values of rd_data and rd_busy follow from this.
- Reads: combinational, zero latency.
  - Register 0 reads all-zero and busy = 0 when ZERO_REG = 1.
  - Addresses >= NREGS read zero and busy = 0.
- Write: takes effect on the rising clk edge when wr_enable = 1 and FSM = IDLE.
  - Only lanes whose mask bit = 1 are updated; unmasked lanes keep their value.
  - When wr_bcast = 1, every masked lane gets wr_data lane 0.
  - Writes are ignored when the mask is all-zero, when the address is >= NREGS, or when wr_addr = 0 and ZERO_REG = 1.
- Bypass: applies when BYPASS = 1, FSM = IDLE, wr_enable = 1, rs_addr[i] == wr_addr and the write is not ignored.
  - Masked lanes of rd_data[i] show the post-broadcast write data; other lanes show the stored values.
  - When BYPASS = 0, reads return the stored values, so the new data is visible the next cycle.
- Scoreboard:
  - rsv_valid sets busy[rsv_addr] at the edge.
  - An accepted write clears busy[wr_addr]; a masked-out (all-zero mask) write still clears it.
  - If a reservation and a write hit the same address in the same cycle, busy ends at 1 (the reservation wins).
  - rd_busy shows the registered busy bits; the current cycle's reservation is not bypassed to it.
  - Reservations are ignored to reg 0 (when ZERO_REG = 1), to addresses >= NREGS, and outside IDLE.
- Clear sequencer FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_ready = 1. clr_req = 1 moves to CLEAR and sets idx = 0.
  - CLEAR: clr_ready = 0. Each cycle, register idx is zeroed (all lanes) and its busy bit cleared, then idx increments. After idx = NREGS-1 the FSM moves to DONE. Total NREGS cycles.
  - DONE: clr_done = 1 for exactly one cycle, then IDLE.
  - In CLEAR and DONE, writes and reservations are dropped (not queued) and bypass is disabled.
  - Reads remain live: registers not yet cleared still return their old contents.
  - clr_req is ignored outside IDLE.
- rst asserted mid-CLEAR: immediate return to IDLE with all registers zero. clr_done is not pulsed.
- idx width is AW+1 bits, so there is no wrap when NREGS is a power of two.

Decomposition:
- Package vrf_pkg holds:
  - enum clr_state_t {IDLE, CLEAR, DONE};
  - default parameter constants;
  - a function that computes the broadcast/masked lane merge.
- One sub-module, vrf_scoreboard: NREGS busy bits with the set/clear/priority rules and the clear-sequencer clear input.
- Storage, bypass and the FSM stay in the top module.

Test Plan:
- Write r3 = {40,30,20,10}, mask 1111; next cycle read r3 on port 0 → {40,30,20,10}. Write r3 with mask 0101 and data {4,3,2,1} → r3 = {40,3,20,1}.
- With BYPASS = 1, write r5 lane0 = 0xDEAD with wr_bcast = 1, mask 1111; in the same cycle, read r5 on ports 0 and 2 → all lanes 0xDEAD, combinationally.
- Write r0 = all 0xFFFFFFFF and rsv r0 → r0 reads 0 and rd_busy = 0.
- rsv r7 → rd_busy = 1 the next cycle. Write r7 → busy 0 the cycle after. Simultaneous rsv r7 and write r7 → busy stays 1.
- Fill r1..r15 with nonzero data and assert clr_req → clr_ready drops; exactly 16 cycles later clr_done pulses once; all registers read 0. A write during CLEAR has no effect.
- Assert rst at CLEAR cycle 5 → all registers 0, clr_ready = 1, no clr_done pulse. After releasing rst, a write to r2 works normally.
